pipe_ctrl: RTL

Central pipeline controller for the five-stage MIPS core. It turns per-stage stall requests into the 6-bit stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. It sequences exception and eret redirection as a two-cycle freeze-then-flush sequence, producing flush and new_pc. A stall watchdog flags pipelines that stay stalled too long.

---
 rtl/pipe_ctrl_pkg.sv | 48 ++++
 rtl/pipe_ctrl_stall_watchdog.sv | 55 +++++
 rtl/pipe_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared constants, state type and stall priority encoder for
//               the five-stage pipeline controller.
//               Stall vector bit map: bit0 pc, bit1 if, bit2 id, bit3 ex,
//               bit4 mem, bit5 wb (1 = hold).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Stall vector encodings: a stalled stage also holds every earlier stage.
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallIf   = 6'b000011;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;
  localparam logic [5:0] StallAll  = 6'b111111;

  localparam logic [31:0] ZeroWord         = 32'h0000_0000;
  localparam logic [31:0] ExcEret          = 32'h0000_000e;
  localparam logic [31:0] ExcVectorDefault = 32'h0000_0020;

  localparam logic Flush        = 1'b1;
  localparam logic StallEnable  = 1'b1;
  localparam logic StallDisable = 1'b0;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Highest (latest) requesting stage wins.
  function automatic logic [5:0] stall_encode(input logic req_mem,
                                              input logic req_ex,
                                              input logic req_id,
                                              input logic req_if);
    logic [5:0] enc;
    enc = StallNone;
    if (req_mem)     enc = StallMem;
    else if (req_ex) enc = StallEx;
    else if (req_id) enc = StallId;
    else if (req_if) enc = StallIf;
    return enc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_stall_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_stall_watchdog
// Description : Counts consecutive stalled cycles and emits one pulse per
//               stall episode once the episode reaches STALL_LIMIT cycles.
// Ports       : clk             - system clock
//               rst             - asynchronous reset, active low
//               stalled_i       - pipeline is stalled in normal run this cycle
//               stall_timeout_o - one-cycle pulse on the STALL_LIMIT-th
//                                 consecutive stalled cycle
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_stall_watchdog #(
  parameter int unsigned STALL_LIMIT = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled_i,
  output logic stall_timeout_o
);

  localparam logic [CNT_W-1:0] C_LIMIT    = CNT_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] C_LIMIT_M1 = CNT_W'(STALL_LIMIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // count_q holds the number of stalled cycles already completed in this
  // episode, so a value of LIMIT-1 while still stalled marks the LIMIT-th
  // cycle. Saturating at LIMIT (one past the trigger value) keeps the pulse
  // from repeating until the stall clears.
  always_comb begin
    count_d = count_q;
    if (!stalled_i) begin
      count_d = '0;
    end else if (count_q >= C_LIMIT_M1) begin
      count_d = C_LIMIT;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign stall_timeout_o = stalled_i && (count_q == C_LIMIT_M1);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Central pipeline controller. Priority-encodes per-stage stall
//               requests, sequences exception/eret redirection as a one-cycle
//               freeze followed by a one-cycle flush, and watches for stalls
//               that last too long.
// Ports       : clk               - system clock
//               rst               - asynchronous reset, active low
//               stallreq_from_*   - stall requests from if/id/ex/mem
//               excepttype_i      - exception code from MEM, 0 = none
//               cp0_epc_i         - current EPC, target of eret
//               stall[5:0]        - per-register hold vector
//               flush             - clear all pipeline registers
//               new_pc[31:0]      - redirect target, valid while flush=1
//               stall_timeout     - watchdog pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = ExcVectorDefault,
  parameter int unsigned STALL_LIMIT = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] new_pc_q;
  logic [31:0] new_pc_d;
  logic [5:0]  stall_comb;
  logic        wd_stalled;

  // During FLUSH the MEM stage contents are being discarded, so requests and
  // exception codes are ignored and the stall vector stays clear.
  always_comb begin
    state_d    = state_q;
    new_pc_d   = new_pc_q;
    stall_comb = StallNone;
    wd_stalled = StallDisable;
    unique case (state_q)
      RUN: begin
        if (excepttype_i != ZeroWord) begin
          stall_comb = StallAll;
          state_d    = FLUSH;
          new_pc_d   = (excepttype_i == ExcEret) ? cp0_epc_i : EXC_VECTOR;
        end else begin
          stall_comb = stall_encode(stallreq_from_mem, stallreq_from_ex,
                                    stallreq_from_id, stallreq_from_if);
          wd_stalled = (stall_comb != StallNone) ? StallEnable : StallDisable;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      new_pc_q <= ZeroWord;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
    end
  end

  // stall is combinational, so it is gated by reset directly.
  assign stall  = rst ? stall_comb : StallNone;
  assign flush  = (state_q == FLUSH) ? Flush : ~Flush;
  assign new_pc = new_pc_q;

  pipe_ctrl_stall_watchdog #(
    .STALL_LIMIT (STALL_LIMIT),
    .CNT_W       (CNT_W)
  ) u_stall_watchdog (
    .clk             (clk),
    .rst             (rst),
    .stalled_i       (rst && wd_stalled),
    .stall_timeout_o (stall_timeout)
  );

endmodule
`default_nettype wire
